// File: rtl/ctech_lib_clkand_pkg.sv
// Shared types and helpers for the multi-channel clock-enable controller.
// State encoding is fixed so downstream debug tooling can decode it directly.
package ctech_lib_clkand_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    WAKE = 2'd1,
    ON   = 2'd2,
    HOLD = 2'd3
  } clkand_state_e;

  // Wake counter must hold WAKE_CYC; keep at least one bit for the WAKE_CYC=0 build.
  function automatic int wake_cnt_w(input int wake_cyc);
    int w;
    w = $clog2(wake_cyc + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ctech_lib_clkand_ch.sv
// One gating channel: OFF/WAKE/ON/HOLD policy with wake delay and hold-off.
// en/ack are registered from the next state so they change on the same edge as the state.
module ctech_lib_clkand_ch
  import ctech_lib_clkand_pkg::*;
#(
  parameter int WAKE_CYC = 2,
  parameter int HOLD_W   = 4
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              want_i,
  input  logic [HOLD_W-1:0] hold_cycles_i,
  output logic              en_o,
  output logic              ack_o,
  output logic              idle_d_o
);

  localparam int               WCW       = wake_cnt_w(WAKE_CYC);
  localparam logic [WCW-1:0]   WAKE_LOAD = WCW'(WAKE_CYC);
  localparam logic [WCW-1:0]   WAKE_ONE  = WCW'(1);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  clkand_state_e     state_q, state_d;
  logic [WCW-1:0]    wake_cnt_q, wake_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              en_q, ack_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= OFF;
      wake_cnt_q <= '0;
      hold_cnt_q <= '0;
      en_q       <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wake_cnt_q <= wake_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      en_q       <= (state_d != OFF);
      ack_q      <= (state_d == ON);
    end
  end

  always_comb begin
    state_d    = state_q;
    wake_cnt_d = wake_cnt_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      OFF: begin
        if (want_i) begin
          if (WAKE_CYC > 0) begin
            state_d    = WAKE;
            wake_cnt_d = WAKE_LOAD;
          end else begin
            state_d = ON;
          end
        end
      end
      // Wake runs to completion regardless of want so the domain always settles.
      WAKE: begin
        if (wake_cnt_q == WAKE_ONE) begin
          state_d    = ON;
          wake_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q - WAKE_ONE;
        end
      end
      ON: begin
        if (!want_i) begin
          if (hold_cycles_i != '0) begin
            state_d    = HOLD;
            hold_cnt_d = hold_cycles_i;
          end else begin
            state_d = OFF;
          end
        end
      end
      HOLD: begin
        if (want_i) begin
          state_d    = ON;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_ONE) begin
          state_d    = OFF;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_ONE;
        end
      end
      default: state_d = OFF;
    endcase
  end

  assign en_o     = en_q;
  assign ack_o    = ack_q;
  assign idle_d_o = (state_d == OFF);

endmodule

// File: rtl/ctech_lib_clkand_ctrl.sv
// Multi-channel clock-enable controller feeding plain AND-style clock gates.
// all_idle is registered from the channels' next states so it tracks en on the same edge.
module ctech_lib_clkand_ctrl
  import ctech_lib_clkand_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int WAKE_CYC = 2,
  parameter int HOLD_W   = 4
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] force_on,
  input  logic [HOLD_W-1:0] hold_cycles,
  output logic [NUM_CH-1:0] en,
  output logic [NUM_CH-1:0] ack,
  output logic              all_idle
);

  logic [NUM_CH-1:0] idle_d;
  logic              all_idle_q;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      ctech_lib_clkand_ch #(
        .WAKE_CYC (WAKE_CYC),
        .HOLD_W   (HOLD_W)
      ) u_ch (
        .clk           (clk),
        .rst_b         (rst_b),
        .want_i        (req[gi] | force_on[gi]),
        .hold_cycles_i (hold_cycles),
        .en_o          (en[gi]),
        .ack_o         (ack[gi]),
        .idle_d_o      (idle_d[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      all_idle_q <= 1'b1;
    end else begin
      all_idle_q <= &idle_d;
    end
  end

  assign all_idle = all_idle_q;

endmodule

// File: tb/tb_ctech_lib_clkand_ctrl.sv
// Directed bench for the clock-enable controller: WAKE_CYC=2 and WAKE_CYC=0 builds share stimulus.
// A timing-level model (active flag, remaining wake/hold cycles) is checked every cycle.
module tb_ctech_lib_clkand_ctrl;

  logic       clk = 1'b0;
  logic       rst_b = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] force_on = '0;
  logic [3:0] hold_cycles = 4'd3;

  logic [3:0] en2, ack2, en0, ack0;
  logic       idle2, idle0;

  int checks = 0;
  int failures = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  ctech_lib_clkand_ctrl #(.NUM_CH(4), .WAKE_CYC(2), .HOLD_W(4)) dut (
    .clk(clk), .rst_b(rst_b), .req(req), .force_on(force_on),
    .hold_cycles(hold_cycles), .en(en2), .ack(ack2), .all_idle(idle2)
  );

  ctech_lib_clkand_ctrl #(.NUM_CH(4), .WAKE_CYC(0), .HOLD_W(4)) dut0 (
    .clk(clk), .rst_b(rst_b), .req(req), .force_on(force_on),
    .hold_cycles(hold_cycles), .en(en0), .ack(ack0), .all_idle(idle0)
  );

  // Model: k=0 is the WAKE_CYC=2 build, k=1 the WAKE_CYC=0 build.
  int m_act [2][4];
  int m_wl  [2][4];
  int m_hl  [2][4];
  logic [3:0] want;
  assign want = req | force_on;

  function automatic int wv(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int k = 0; k < 2; k++)
        for (int c = 0; c < 4; c++) begin
          m_act[k][c] <= 0;
          m_wl[k][c]  <= 0;
          m_hl[k][c]  <= 0;
        end
    end else begin
      for (int k = 0; k < 2; k++)
        for (int c = 0; c < 4; c++) begin
          if (m_act[k][c] == 0) begin
            if (want[c]) begin
              m_act[k][c] <= 1;
              m_wl[k][c]  <= wv(k);
              m_hl[k][c]  <= 0;
            end
          end else if (m_wl[k][c] > 0) begin
            m_wl[k][c] <= m_wl[k][c] - 1;
          end else if (m_hl[k][c] > 0) begin
            if (want[c]) m_hl[k][c] <= 0;
            else begin
              m_hl[k][c] <= m_hl[k][c] - 1;
              if (m_hl[k][c] == 1) m_act[k][c] <= 0;
            end
          end else if (!want[c]) begin
            if (hold_cycles == 4'd0) m_act[k][c] <= 0;
            else m_hl[k][c] <= int'(hold_cycles);
          end
        end
    end
  end

  function automatic logic [3:0] exp_en(input int k);
    logic [3:0] v;
    for (int c = 0; c < 4; c++) v[c] = (m_act[k][c] != 0);
    return v;
  endfunction

  function automatic logic [3:0] exp_ack(input int k);
    logic [3:0] v;
    for (int c = 0; c < 4; c++)
      v[c] = (m_act[k][c] != 0) && (m_wl[k][c] == 0) && (m_hl[k][c] == 0);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expv);
    checks++;
    if (actual !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, actual, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("model_en_w2",   32'(en2),   32'(exp_en(0)));
      chk("model_ack_w2",  32'(ack2),  32'(exp_ack(0)));
      chk("model_idle_w2", 32'(idle2), 32'(exp_en(0) == 4'd0));
      chk("model_en_w0",   32'(en0),   32'(exp_en(1)));
      chk("model_ack_w0",  32'(ack0),  32'(exp_ack(1)));
      chk("model_idle_w0", 32'(idle0), 32'(exp_en(1) == 4'd0));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #1 rst_b = 1'b0;
    #1 cmp_on = 1'b1;

    // Reset with random requests.
    repeat (3) begin
      tick();
      req = 4'($urandom);
    end
    tick();
    chk("rst_en", 32'(en2), 32'h0);
    chk("rst_ack", 32'(ack2), 32'h0);
    chk("rst_idle", 32'(idle2), 32'h1);
    $display("step reset: en=%b ack=%b idle=%b", en2, ack2, idle2);

    req = 4'b0001;
    rst_b = 1'b1;
    tick();
    chk("wake_e1_en0", 32'(en2[0]), 32'h1);
    chk("wake_e1_ack0", 32'(ack2[0]), 32'h0);
    chk("wake_e1_idle", 32'(idle2), 32'h0);
    chk("w0_ack_with_en", 32'(ack0[0]), 32'h1);
    tick();
    chk("wake_e2_ack0", 32'(ack2[0]), 32'h0);
    tick();
    chk("wake_e3_ack0", 32'(ack2[0]), 32'h1);
    $display("step wake: en=%b ack=%b", en2, ack2);

    // Zero hold: ON->OFF in one edge.
    hold_cycles = 4'd0;
    req = 4'b0000;
    tick();
    chk("hold0_en0", 32'(en2[0]), 32'h0);
    chk("hold0_idle", 32'(idle2), 32'h1);
    $display("step hold0: en=%b idle=%b", en2, idle2);

    // Hold-off of 3; hold_cycles changed mid-HOLD must be ignored.
    hold_cycles = 4'd3;
    req = 4'b0010;
    repeat (4) tick();
    req = 4'b0000;
    tick();
    chk("hold_ack1", 32'(ack2[1]), 32'h0);
    chk("hold_en1_c1", 32'(en2[1]), 32'h1);
    hold_cycles = 4'd9;
    tick();
    chk("hold_en1_c2", 32'(en2[1]), 32'h1);
    tick();
    chk("hold_en1_c3", 32'(en2[1]), 32'h1);
    tick();
    chk("hold_en1_off", 32'(en2[1]), 32'h0);
    chk("hold_idle", 32'(idle2), 32'h1);
    $display("step holdoff: en=%b ack=%b idle=%b", en2, ack2, idle2);

    // Re-request in the 2nd HOLD cycle.
    hold_cycles = 4'd5;
    req = 4'b0100;
    repeat (4) tick();
    req = 4'b0000;
    tick();
    tick();
    chk("rereq_hold_en2", 32'(en2[2]), 32'h1);
    req = 4'b0100;
    tick();
    chk("rereq_ack2", 32'(ack2[2]), 32'h1);
    chk("rereq_en2", 32'(en2[2]), 32'h1);
    req = 4'b0000;
    repeat (7) tick();
    $display("step rereq: en=%b ack=%b", en2, ack2);

    // One-cycle pulse: wake completes, one ON cycle, then 2 HOLD cycles.
    hold_cycles = 4'd2;
    req = 4'b1000;
    tick();
    req = 4'b0000;
    chk("pulse_e0_en3", 32'(en2[3]), 32'h1);
    tick();
    chk("pulse_e1_en3", 32'(en2[3]), 32'h1);
    chk("pulse_e1_ack3", 32'(ack2[3]), 32'h0);
    tick();
    chk("pulse_e2_ack3", 32'(ack2[3]), 32'h1);
    tick();
    chk("pulse_e3_ack3", 32'(ack2[3]), 32'h0);
    chk("pulse_e3_en3", 32'(en2[3]), 32'h1);
    tick();
    chk("pulse_e4_en3", 32'(en2[3]), 32'h1);
    tick();
    chk("pulse_e5_en3", 32'(en2[3]), 32'h0);
    $display("step pulse: en=%b ack=%b", en2, ack2);

    // Async reset mid-HOLD, then force_on keeps channel 0 ON.
    hold_cycles = 4'd4;
    force_on = 4'b0001;
    req = 4'b0010;
    repeat (3) tick();
    req = 4'b0000;
    tick();
    chk("pre_rst_en1", 32'(en2[1]), 32'h1);
    #2 rst_b = 1'b0;
    #1;
    chk("async_rst_en", 32'(en2), 32'h0);
    chk("async_rst_ack", 32'(ack2), 32'h0);
    chk("async_rst_idle", 32'(idle2), 32'h1);
    chk("async_rst_en_w0", 32'(en0), 32'h0);
    $display("step async reset: en=%b ack=%b idle=%b", en2, ack2, idle2);
    tick();
    rst_b = 1'b1;
    repeat (20) tick();
    chk("force_en0", 32'(en2[0]), 32'h1);
    chk("force_ack0", 32'(ack2[0]), 32'h1);
    chk("force_en_others", 32'(en2[3:1]), 32'h0);
    $display("step force_on: en=%b ack=%b", en2, ack2);

    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
